morse_keyer_tx: RTL and testbench

MORSE_KEYER_TX -- requirements
Module: morse_keyer_tx

---
 rtl/morse_pkg.sv | 27 ++
 rtl/morse_encode_rom.sv | 69 ++++++
 rtl/morse_keyer_tx.sv | 114 +++++++++++
 tb/tb_morse_keyer_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and ASCII constants for the Morse keyer.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        WORD_GAP
    } state_t;

    // Elements are left-aligned in pattern and sent MSB-first, 1 = dash.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pattern;
    } code_t;

    localparam logic [7:0] ASCII_SPACE   = 8'd32;
    localparam logic [7:0] ASCII_DIGIT_0 = 8'd48;
    localparam logic [7:0] ASCII_DIGIT_9 = 8'd57;
    localparam logic [7:0] ASCII_UPPER_A = 8'd65;
    localparam logic [7:0] ASCII_UPPER_Z = 8'd90;
    localparam logic [7:0] ASCII_LOWER_A = 8'd97;
    localparam logic [7:0] ASCII_LOWER_Z = 8'd122;
    localparam logic [7:0] CASE_FOLD     = 8'd32;

endpackage

// File: rtl/morse_encode_rom.sv
// Combinational ASCII to ITU Morse lookup (letters, digits, space).
module morse_encode_rom
    import morse_pkg::*;
(
    input  logic [31:0] ascii,
    output logic        supported,
    output logic        is_space,
    output logic [2:0]  len,
    output logic [4:0]  pattern
);

    logic       narrow;
    logic [7:0] ch;
    logic [7:0] key;
    code_t      code;

    always_comb begin
        narrow = (ascii[31:8] == 24'd0);
        ch     = ascii[7:0];
        key    = ch;
        if (ch >= ASCII_LOWER_A && ch <= ASCII_LOWER_Z)
            key = ch - CASE_FOLD;
        code = '0;
        case (key)
            "A": code = {3'd2, 5'b01000};
            "B": code = {3'd4, 5'b10000};
            "C": code = {3'd4, 5'b10100};
            "D": code = {3'd3, 5'b10000};
            "E": code = {3'd1, 5'b00000};
            "F": code = {3'd4, 5'b00100};
            "G": code = {3'd3, 5'b11000};
            "H": code = {3'd4, 5'b00000};
            "I": code = {3'd2, 5'b00000};
            "J": code = {3'd4, 5'b01110};
            "K": code = {3'd3, 5'b10100};
            "L": code = {3'd4, 5'b01000};
            "M": code = {3'd2, 5'b11000};
            "N": code = {3'd2, 5'b10000};
            "O": code = {3'd3, 5'b11100};
            "P": code = {3'd4, 5'b01100};
            "Q": code = {3'd4, 5'b11010};
            "R": code = {3'd3, 5'b01000};
            "S": code = {3'd3, 5'b00000};
            "T": code = {3'd1, 5'b10000};
            "U": code = {3'd3, 5'b00100};
            "V": code = {3'd4, 5'b00010};
            "W": code = {3'd3, 5'b01100};
            "X": code = {3'd4, 5'b10010};
            "Y": code = {3'd4, 5'b10110};
            "Z": code = {3'd4, 5'b11000};
            "0": code = {3'd5, 5'b11111};
            "1": code = {3'd5, 5'b01111};
            "2": code = {3'd5, 5'b00111};
            "3": code = {3'd5, 5'b00011};
            "4": code = {3'd5, 5'b00001};
            "5": code = {3'd5, 5'b00000};
            "6": code = {3'd5, 5'b10000};
            "7": code = {3'd5, 5'b11000};
            "8": code = {3'd5, 5'b11100};
            "9": code = {3'd5, 5'b11110};
            default: code = '0;
        endcase
        supported = narrow && (code.len != 3'd0);
        is_space  = narrow && (ch == ASCII_SPACE);
        len       = supported ? code.len : 3'd0;
        pattern   = supported ? code.pattern : 5'd0;
    end

endmodule

// File: rtl/morse_keyer_tx.sv
// Morse keyer: accepts one ASCII character at a time and keys it out.
module morse_keyer_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        key_out,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(4 * UNIT_CYCLES);
    localparam logic [CW-1:0] DOT_LOAD  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LOAD = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] WORD_LOAD = CW'(4 * UNIT_CYCLES - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    pat, pat_n;
    logic [2:0]    rem, rem_n;
    logic          armed;

    logic       enc_supported;
    logic       enc_space;
    logic [2:0] enc_len;
    logic [4:0] enc_pattern;

    morse_encode_rom u_rom (
        .ascii     (char_in),
        .supported (enc_supported),
        .is_space  (enc_space),
        .len       (enc_len),
        .pattern   (enc_pattern)
    );

    // armed keeps ready low until the first edge after reset release
    assign char_ready = armed && (state == IDLE);
    assign busy       = armed && (state != IDLE);
    assign key_out    = (state == MARK);
    assign done       = (state == CHAR_GAP || state == WORD_GAP)
                        && (cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pat   <= '0;
            rem   <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pat   <= pat_n;
            rem   <= rem_n;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
        pat_n   = pat;
        rem_n   = rem;
        unique case (state)
            IDLE: begin
                if (char_valid && char_ready) begin
                    pat_n = enc_pattern;
                    rem_n = enc_len;
                    if (enc_supported) begin
                        state_n = MARK;
                        cnt_n   = enc_pattern[4] ? DASH_LOAD : DOT_LOAD;
                    end else if (enc_space) begin
                        state_n = WORD_GAP;
                        cnt_n   = WORD_LOAD;
                    end else begin
                        // unsupported: one zero-length gap yields done next cycle
                        state_n = CHAR_GAP;
                        cnt_n   = '0;
                    end
                end
            end
            MARK: begin
                if (cnt == '0) begin
                    pat_n = pat << 1;
                    rem_n = rem - 3'd1;
                    if (rem <= 3'd1) begin
                        state_n = CHAR_GAP;
                        cnt_n   = DASH_LOAD;
                    end else begin
                        state_n = ELEM_GAP;
                        cnt_n   = DOT_LOAD;
                    end
                end
            end
            ELEM_GAP: begin
                if (cnt == '0) begin
                    state_n = MARK;
                    cnt_n   = pat[4] ? DASH_LOAD : DOT_LOAD;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (cnt == '0)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_morse_keyer_tx.sv
// Directed bench for morse_keyer_tx with UNIT_CYCLES=4.
module tb_morse_keyer_tx;

    logic        clock;
    logic        reset;
    logic [31:0] char_in;
    logic        char_valid;
    logic        char_ready;
    logic        key_out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int exp_r[12];
    int exp_n;

    morse_keyer_tx #(.UNIT_CYCLES(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Runs: positive = key high cycles, negative = key low cycles.
    task automatic xmit(input string tag, input logic [31:0] c,
                        input logic [31:0] nxt, input bit hold,
                        input bit poke);
        int  obs[$];
        int  run;
        bit  lvl;
        bit  seen;
        int  cyc;
        char_in    = c;
        char_valid = 1'b1;
        check({tag, "_rdy"}, int'(char_ready), 1);
        @(negedge clock);
        if (hold) char_in = nxt;
        else char_valid = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        run  = 0;
        lvl  = key_out;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 400) begin
            if (poke && cyc == 5) begin
                char_in    = 32'd84;
                char_valid = 1'b1;
            end
            if (poke && cyc == 6) char_valid = 1'b0;
            if (key_out != lvl) begin
                obs.push_back(lvl ? run : -run);
                run = 0;
                lvl = key_out;
            end
            run++;
            seen = done;
            cyc++;
            if (!seen) @(negedge clock);
        end
        obs.push_back(lvl ? run : -run);
        check({tag, "_done"}, int'(seen), 1);
        check({tag, "_nrun"}, obs.size(), exp_n);
        for (int i = 0; i < exp_n && i < obs.size(); i++)
            check($sformatf("%s_run%0d", tag, i), obs[i], exp_r[i]);
        @(negedge clock);
        check({tag, "_done_clr"}, int'(done), 0);
        check({tag, "_rdy_after"}, int'(char_ready), 1);
        check({tag, "_key_after"}, int'(key_out), 0);
    endtask

    initial begin
        int d0;
        reset      = 1'b1;
        char_in    = '0;
        char_valid = 1'b0;
        #1;
        check("rst_key", int'(key_out), 0);
        check("rst_rdy", int'(char_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rel_rdy_pre", int'(char_ready), 0);
        @(negedge clock);
        check("rel_rdy_post", int'(char_ready), 1);

        exp_r = '{4, -12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_n = 2;
        xmit("E", 32'd69, 32'd0, 1'b0, 1'b0);

        exp_r = '{4, -4, 12, -12, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_n = 4;
        d0 = done_cnt;
        xmit("A", 32'd65, 32'd0, 1'b0, 1'b0);
        check("A_one_done", done_cnt - d0, 1);

        exp_r = '{4, -12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_n = 2;
        xmit("e_b2b", 32'd101, 32'd48, 1'b1, 1'b0);
        exp_r = '{12, -4, 12, -4, 12, -4, 12, -4, 12, -12, 0, 0};
        exp_n = 10;
        xmit("0_b2b", 32'd48, 32'd0, 1'b0, 1'b0);

        exp_r = '{-16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_n = 1;
        xmit("space", 32'd32, 32'd0, 1'b0, 1'b0);
        exp_r = '{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_n = 1;
        xmit("nul", 32'd0, 32'd0, 1'b0, 1'b0);
        xmit("tilde", 32'h7E, 32'd0, 1'b0, 1'b0);
        xmit("wide", 32'h0000_0141, 32'd0, 1'b0, 1'b0);

        exp_r = '{4, -4, 12, -12, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_n = 4;
        xmit("A_poke", 32'd65, 32'd0, 1'b0, 1'b1);

        d0         = done_cnt;
        char_in    = 32'd84;
        char_valid = 1'b1;
        check("T_rdy", int'(char_ready), 1);
        @(negedge clock);
        char_valid = 1'b0;
        check("T_key", int'(key_out), 1);
        repeat (5) @(negedge clock);
        check("T_key6", int'(key_out), 1);
        reset = 1'b1;
        #1;
        check("T_rst_key", int'(key_out), 0);
        check("T_rst_rdy", int'(char_ready), 0);
        check("T_rst_busy", int'(busy), 0);
        check("T_rst_done", int'(done), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("T_rel_rdy_pre", int'(char_ready), 0);
        @(negedge clock);
        check("T_rel_rdy", int'(char_ready), 1);
        check("T_rel_key", int'(key_out), 0);
        repeat (20) @(negedge clock);
        check("T_no_done", done_cnt - d0, 0);
        check("T_idle_key", int'(key_out), 0);

        exp_r = '{4, -12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_n = 2;
        xmit("E_after_rst", 32'd69, 32'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
